// File: rtl/seg7_scan_decoder_if.sv
// rtl/seg7_scan_decoder_if.sv - multiplexed seven-segment display bus (segments plus anode selects)
interface seg7_scan_decoder_if #(
  parameter int NUM_DIGITS = 4
);
  logic [6:0]            seg;
  logic [NUM_DIGITS-1:0] an;

  modport master (output seg, output an);
  modport slave  (input seg, input an);
endinterface

// File: rtl/seg7_scan_decoder.sv
// rtl/seg7_scan_decoder.sv - recovers per-digit codes from a scanned seven-segment bus
// Optional macro SEG7_ERR_COUNT_EN adds a saturating err_count output.
module seg7_scan_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  seg7_scan_decoder_if.slave      bus,
  output logic [NUM_DIGITS*5-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    update_pulse,
  output logic [2:0]              update_index,
  output logic                    pattern_err,
  output logic                    frame_valid
`ifdef SEG7_ERR_COUNT_EN
  ,
  output logic [7:0]              err_count
`endif
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;

  state_t                state, state_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic [6:0]            s_seg, p_seg;
  logic [NUM_DIGITS-1:0] s_an, p_an;
  logic [3:0]            nzero;
  logic [2:0]            sel_idx;
  logic                  legal, stable, capture;
  logic [4:0]            code;

  // p_* holds the previous cycle's sampled bus so stability is judged on registered data only
  always_ff @(posedge clk) begin
    if (reset) begin
      s_seg <= 7'h7f;
      s_an  <= '1;
      p_seg <= 7'h7f;
      p_an  <= '1;
    end else begin
      s_seg <= bus.seg;
      s_an  <= bus.an;
      p_seg <= s_seg;
      p_an  <= s_an;
    end
  end

  always_comb begin
    nzero   = 4'd0;
    sel_idx = 3'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!s_an[i]) begin
        nzero   = nzero + 4'd1;
        sel_idx = 3'(i);
      end
    end
  end

  assign legal  = (nzero == 4'd1);
  assign stable = (s_seg == p_seg) && (s_an == p_an);

  always_comb begin
    case (s_seg)
      7'b0000001: code = 5'd0;
      7'b1001111: code = 5'd1;
      7'b0010010: code = 5'd2;
      7'b0000110: code = 5'd3;
      7'b1001100: code = 5'd4;
      7'b0100100: code = 5'd5;
      7'b0100000: code = 5'd6;
      7'b0001111: code = 5'd7;
      7'b0000000: code = 5'd8;
      7'b0000100: code = 5'd9;
      7'b1111111: code = 5'd31;
      default:    code = 5'd30;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    capture = 1'b0;
    if (!legal) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_n = SETTLE;
          cnt_n   = CW'(1);
        end
        SETTLE: begin
          if (!stable) begin
            cnt_n = CW'(1);
          end else if (cnt == CW'(SETTLE_CYCLES)) begin
            capture = 1'b1;
            state_n = HELD;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        HELD: begin
          if (!stable) begin
            state_n = SETTLE;
            cnt_n   = CW'(1);
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      digits       <= {NUM_DIGITS{5'd31}};
      digit_valid  <= '0;
      update_pulse <= 1'b0;
      update_index <= 3'd0;
      pattern_err  <= 1'b0;
      frame_valid  <= 1'b0;
    end else begin
      update_pulse <= capture;
      pattern_err  <= capture && (code == 5'd30);
      frame_valid  <= &digit_valid;
      if (capture) update_index <= sel_idx;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (capture && sel_idx == 3'(i)) begin
          digits[5*i +: 5] <= code;
          digit_valid[i]   <= 1'b1;
        end
      end
    end
  end

`ifdef SEG7_ERR_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      err_count <= 8'd0;
    end else if (capture && code == 5'd30 && err_count != 8'd255) begin
      err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb/tb_seg7_scan_decoder.sv - self-checking bench for seg7_scan_decoder
// Run-length model of the display bus plus directed literal checks.
module tb_seg7_scan_decoder;
  localparam int ND = 4;
  localparam int SC = 4;

  logic          clk;
  logic          reset;
  logic [ND*5-1:0] digits;
  logic [ND-1:0] digit_valid;
  logic          update_pulse;
  logic [2:0]    update_index;
  logic          pattern_err;
  logic          frame_valid;
`ifdef SEG7_ERR_COUNT_EN
  logic [7:0]    err_count;
`endif

  seg7_scan_decoder_if #(.NUM_DIGITS(ND)) bus ();

  seg7_scan_decoder #(.NUM_DIGITS(ND), .SETTLE_CYCLES(SC)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus.slave),
    .digits       (digits),
    .digit_valid  (digit_valid),
    .update_pulse (update_pulse),
    .update_index (update_index),
    .pattern_err  (pattern_err),
    .frame_valid  (frame_valid)
`ifdef SEG7_ERR_COUNT_EN
    ,
    .err_count    (err_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;
  int n_pulse = 0;
  int n_err   = 0;

  logic [6:0] lut [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                           7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

  function automatic int decode(logic [6:0] s);
    if (s == 7'h7f) return 31;
    for (int i = 0; i < 10; i++) if (lut[i] == s) return i;
    return 30;
  endfunction

  task automatic check(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a capture happens on the edge after a legal bus value has been sampled SC+1 times in a row
  int         m_digits [ND];
  logic [ND-1:0] m_valid;
  logic       m_pulse, m_err, m_fv, m_have, started;
  int         m_idx, m_ecnt, m_run;
  logic [6:0] m_seg;
  logic [ND-1:0] m_an;

  initial started = 1'b0;

  always @(posedge clk) begin : model
    int k;
    int c;
    int nz;
    if (reset) begin
      for (int i = 0; i < ND; i++) m_digits[i] <= 31;
      m_valid <= '0;
      m_pulse <= 1'b0;
      m_err   <= 1'b0;
      m_fv    <= 1'b0;
      m_idx   <= 0;
      m_ecnt  <= 0;
      m_have  <= 1'b0;
      m_run   <= 0;
      started <= 1'b1;
    end else begin
      nz = 0;
      k  = 0;
      for (int i = 0; i < ND; i++) if (!m_an[i]) begin nz++; k = i; end
      m_pulse <= 1'b0;
      m_err   <= 1'b0;
      m_fv    <= &m_valid;
      if (m_have && m_run == SC + 1 && nz == 1) begin
        c = decode(m_seg);
        m_digits[k] <= c;
        m_valid[k]  <= 1'b1;
        m_pulse     <= 1'b1;
        m_idx       <= k;
        m_err       <= (c == 30);
        if (c == 30 && m_ecnt < 255) m_ecnt <= m_ecnt + 1;
      end
      if (m_have && bus.seg == m_seg && bus.an == m_an)
        m_run <= (m_run > SC + 1) ? m_run : m_run + 1;
      else
        m_run <= 1;
      m_seg  <= bus.seg;
      m_an   <= bus.an;
      m_have <= 1'b1;
    end
  end

  function automatic int pack_digits();
    int r = 0;
    for (int i = 0; i < ND; i++) r |= (m_digits[i] & 31) << (5 * i);
    return r;
  endfunction

  always @(negedge clk) begin : compare
    if (started) begin
      check("digits", int'(digits), pack_digits());
      check("digit_valid", int'(digit_valid), int'(m_valid));
      check("update_pulse", int'(update_pulse), int'(m_pulse));
      check("update_index", int'(update_index), m_idx);
      check("pattern_err", int'(pattern_err), int'(m_err));
      check("frame_valid", int'(frame_valid), int'(m_fv));
`ifdef SEG7_ERR_COUNT_EN
      check("err_count", int'(err_count), m_ecnt);
`endif
      if (update_pulse) n_pulse++;
      if (pattern_err) n_err++;
    end
  end

  task automatic apply(input logic [6:0] s, input logic [ND-1:0] a, input int n);
    bus.seg = s;
    bus.an  = a;
    repeat (n) @(negedge clk);
  endtask

  initial begin : stim
    int p0;
    int e0;
    logic [ND*5-1:0] want;
    reset   = 1'b1;
    bus.seg = 7'h7f;
    bus.an  = '1;
    repeat (2) @(negedge clk);
    check("reset_digits", int'(digits), 20'hfffff);
    check("reset_valid", int'(digit_valid), 0);
    check("reset_frame", int'(frame_valid), 0);
    reset = 1'b0;

    // single capture of "2" on digit 0
    p0 = n_pulse;
    apply(7'b0010010, 4'b1110, 8);
    check("t1_pulses", n_pulse - p0, 1);
    check("t1_digit0", int'(digits[4:0]), 2);
    check("t1_model_digit0", m_digits[0], 2);
    check("t1_valid", int'(digit_valid), 1);
    check("t1_index", int'(update_index), 0);

    // scan 9,5,0,7 across digits 0..3
    p0 = n_pulse;
    apply(7'b0000100, 4'b1110, 6);
    apply(7'b0100100, 4'b1101, 6);
    apply(7'b0000001, 4'b1011, 6);
    apply(7'b0001111, 4'b0111, 8);
    want = {5'd7, 5'd0, 5'd5, 5'd9};
    check("t2_pulses", n_pulse - p0, 4);
    check("t2_digits", int'(digits), int'(want));
    check("t2_frame", int'(frame_valid), 1);
    check("t2_index", int'(update_index), 3);

    // chattering pattern never settles, then settles on 4
    p0 = n_pulse;
    for (int i = 0; i < 4; i++) begin
      apply(7'b0000110, 4'b1110, 2);
      apply(7'b1001100, 4'b1110, 2);
    end
    check("t3_no_pulse", n_pulse - p0, 0);
    apply(7'b1001100, 4'b1110, 8);
    check("t3_pulses", n_pulse - p0, 1);
    check("t3_digit0", int'(digits[4:0]), 4);

    // two anodes low, then none: never captures
    p0   = n_pulse;
    want = digits;
    apply(7'b0000000, 4'b1100, 10);
    apply(7'b0000000, 4'b1111, 5);
    check("t4_no_pulse", n_pulse - p0, 0);
    check("t4_digits", int'(digits), int'(want));

    // invalid pattern on digit 2, then repeated to saturate
    e0 = n_err;
    apply(7'b1111110, 4'b1011, 7);
    check("t5_digit2", int'(digits[14:10]), 30);
    check("t5_err_pulses", n_err - e0, 1);
`ifdef SEG7_ERR_COUNT_EN
    check("t5_err_count1", int'(err_count), 1);
`endif
    apply(7'b1111110, 4'b1111, 1);
    for (int i = 0; i < 299; i++) begin
      apply(7'b1111110, 4'b1011, 6);
      apply(7'b1111110, 4'b1111, 1);
    end
    check("t5_err_pulses_all", n_err - e0, 300);
`ifdef SEG7_ERR_COUNT_EN
    check("t5_err_count_sat", int'(err_count), 255);
`endif

    // reset with the settle count at 3 discards the pending capture
    p0 = n_pulse;
    apply(7'b0000000, 4'b0111, 4);
    reset = 1'b1;
    @(negedge clk);
    check("t6_no_pulse", n_pulse - p0, 0);
    check("t6_digits", int'(digits), 20'hfffff);
    check("t6_valid", int'(digit_valid), 0);
    check("t6_index", int'(update_index), 0);
    check("t6_frame", int'(frame_valid), 0);
    check("t6_perr", int'(pattern_err), 0);
    reset = 1'b0;
    apply(7'h7f, 4'b1111, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
